// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - nibble-serial key loader with atomic commit, load timeout and gated increments
module key_load_ctrl #(
  parameter int KEY_SIZE    = 4,
  parameter int NUM_NIBBLES = 4,
  parameter int TIMEOUT     = 8,
  localparam int KEY_WIDTH  = KEY_SIZE * NUM_NIBBLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_key,
  input  logic [KEY_SIZE-1:0]  key_data,
  input  logic                 do_incr_in,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 incr_out,
  output logic                 busy,
  output logic                 abort_pulse
);

  localparam int CW = $clog2(NUM_NIBBLES + 1);
  localparam logic [CW-1:0] LAST_NIB = CW'(NUM_NIBBLES - 1);
  localparam logic [7:0]    TO8      = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  state_t                 state;
  logic [KEY_WIDTH-1:0]   shreg;
  logic [CW-1:0]          nibble_cnt;
  logic [7:0]             gap_cnt;
  logic                   has_key;
  logic [KEY_WIDTH-1:0]   shifted;

  // MSB-first: the oldest nibble ends up in the top bits of the key
  assign shifted = KEY_WIDTH'({shreg, key_data});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      nibble_cnt  <= '0;
      gap_cnt     <= '0;
      has_key     <= 1'b0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      incr_out    <= 1'b0;
      busy        <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      incr_out    <= (state == VALID) && do_incr_in && !load_key;
      case (state)
        IDLE, VALID: begin
          if (load_key) begin
            gap_cnt <= '0;
            if (NUM_NIBBLES == 1) begin
              key_out    <= KEY_WIDTH'(key_data);
              key_valid  <= 1'b1;
              has_key    <= 1'b1;
              nibble_cnt <= '0;
              busy       <= 1'b0;
              state      <= VALID;
            end else begin
              shreg      <= KEY_WIDTH'(key_data);
              nibble_cnt <= CW'(1);
              key_valid  <= 1'b0;
              busy       <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_key) begin
            gap_cnt <= '0;
            if (nibble_cnt == LAST_NIB) begin
              key_out    <= shifted;
              key_valid  <= 1'b1;
              has_key    <= 1'b1;
              nibble_cnt <= '0;
              shreg      <= '0;
              busy       <= 1'b0;
              state      <= VALID;
            end else begin
              shreg      <= shifted;
              nibble_cnt <= nibble_cnt + CW'(1);
            end
          end else if (gap_cnt >= TO8 - 8'd1) begin
            // partial key is dropped; the committed key (if any) becomes live again
            shreg       <= '0;
            nibble_cnt  <= '0;
            gap_cnt     <= '0;
            abort_pulse <= 1'b1;
            busy        <= 1'b0;
            key_valid   <= has_key;
            state       <= has_key ? VALID : IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - directed self-checking bench for key_load_ctrl
module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_key;
  logic [3:0]  key_data;
  logic        do_incr_in;
  logic [15:0] key_out;
  logic        key_valid;
  logic        incr_out;
  logic        busy;
  logic        abort_pulse;

  int checks = 0;
  int errors = 0;

  key_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_key   (load_key),
    .key_data   (key_data),
    .do_incr_in (do_incr_in),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .incr_out   (incr_out),
    .busy       (busy),
    .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input logic lk, input logic [3:0] kd, input logic inc);
    load_key   = lk;
    key_data   = kd;
    do_incr_in = inc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 4'h9, 1'b1);
    checks++;
    if ({key_out, key_valid, incr_out, busy, abort_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got key=%h v=%b i=%b b=%b a=%b want all 0",
               key_out, key_valid, incr_out, busy, abort_pulse);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    step(1'b1, 4'hA, 1'b0);
    checks++;
    if (busy !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_first_nibble: busy=%b valid=%b want 1/0", busy, key_valid);
    end
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    checks++;
    if (key_out !== 16'h0000) begin
      errors++;
      $display("FAIL load_partial_hidden: key_out=%h want 0000", key_out);
    end
    step(1'b1, 4'hC, 1'b0);
    checks++;
    if (key_out !== 16'hA53C || key_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_commit: key=%h v=%b b=%b want a53c/1/0", key_out, key_valid, busy);
    end
  endtask

  task automatic test_incr();
    checks++;
    if (incr_out !== 1'b0) begin
      errors++;
      $display("FAIL incr_idle_before: incr_out=%b want 0", incr_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b1);
      checks++;
      if (incr_out !== 1'b1) begin
        errors++;
        $display("FAIL incr_pass_%0d: incr_out=%b want 1", i, incr_out);
      end
    end
    step(1'b0, 4'h0, 1'b0);
    checks++;
    if (incr_out !== 1'b0) begin
      errors++;
      $display("FAIL incr_release: incr_out=%b want 0", incr_out);
    end
    step(1'b1, 4'hA, 1'b1);
    checks++;
    if (incr_out !== 1'b0 || busy !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL incr_vs_load: incr=%b busy=%b v=%b want 0/1/0", incr_out, busy, key_valid);
    end
    step(1'b1, 4'h5, 1'b1);
    checks++;
    if (incr_out !== 1'b0) begin
      errors++;
      $display("FAIL incr_in_load: incr_out=%b want 0", incr_out);
    end
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    checks++;
    if (key_out !== 16'hA53C || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL incr_reload: key=%h v=%b want a53c/1", key_out, key_valid);
    end
  endtask

  task automatic test_abort_valid();
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (i < 8) begin
        checks++;
        if (abort_pulse !== 1'b0 || busy !== 1'b1 || key_out !== 16'hA53C) begin
          errors++;
          $display("FAIL abort_v_wait_%0d: a=%b b=%b key=%h want 0/1/a53c",
                   i, abort_pulse, busy, key_out);
        end
      end
    end
    checks++;
    if (abort_pulse !== 1'b1 || key_out !== 16'hA53C || key_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_v_fire: a=%b key=%h v=%b b=%b want 1/a53c/1/0",
               abort_pulse, key_out, key_valid, busy);
    end
    step(1'b0, 4'h0, 1'b1);
    checks++;
    if (abort_pulse !== 1'b0 || incr_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_v_after: a=%b incr=%b want 0/1 (back in VALID)", abort_pulse, incr_out);
    end
  endtask

  task automatic test_abort_idle();
    do_reset();
    step(1'b1, 4'h1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0);
    checks++;
    if (abort_pulse !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0 || key_out !== 16'h0) begin
      errors++;
      $display("FAIL abort_i_fire: a=%b v=%b b=%b key=%h want 1/0/0/0000",
               abort_pulse, key_valid, busy, key_out);
    end
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    checks++;
    if (incr_out !== 1'b0 || abort_pulse !== 1'b0) begin
      errors++;
      $display("FAIL abort_i_idle: incr=%b a=%b want 0/0", incr_out, abort_pulse);
    end
  endtask

  task automatic test_gap();
    step(1'b1, 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1);
    checks++;
    if (busy !== 1'b1 || incr_out !== 1'b0 || abort_pulse !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: b=%b incr=%b a=%b want 1/0/0", busy, incr_out, abort_pulse);
    end
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    checks++;
    if (key_out !== 16'h1234 || key_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_commit: key=%h v=%b b=%b want 1234/1/0", key_out, key_valid, busy);
    end
  endtask

  task automatic test_reset_midload();
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h9, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 4'hE, 1'b1);
    checks++;
    if ({key_out, key_valid, incr_out, busy, abort_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL midload_reset: key=%h v=%b i=%b b=%b a=%b want all 0",
               key_out, key_valid, incr_out, busy, abort_pulse);
    end
    rst_n = 1'b1;
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    checks++;
    if (key_out !== 16'hF0F0 || key_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_reload: key=%h v=%b b=%b want f0f0/1/0", key_out, key_valid, busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_key   = 1'b0;
    key_data   = 4'h0;
    do_incr_in = 1'b0;
    test_reset();
    test_load();
    test_incr();
    test_abort_valid();
    test_abort_idle();
    test_gap();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
